uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte-stream requesters. It sits between client blocks (command responder, debug/status streamers) and the UART TX path. Each byte is handed to the transmitter as a one-cycle `tx_start` pulse, and the arbiter waits for `tx_done` before sending the next byte. A granted requester keeps the transmitter for a multi-byte packet until it marks the last byte or hits a burst cap. A watchdog recovers the arbiter if the transmitter stops responding.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between byte-stream requesters, the arbiter and the UART transmitter.
// Byte transfer: req_valid[i] & req_ready[i] high at a rising clk edge moves lane i.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_done;
    logic               grant_active;
    logic [IDW-1:0]     grant_id;
    logic               tx_timeout;
    logic [1:0]         fsm_state;

    modport master (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, grant_active, grant_id, tx_timeout, fsm_state
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, grant_active, grant_id, tx_timeout, fsm_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte-stream requesters,
// with packet bursts, a per-grant burst cap and a tx_done watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 4096
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] last_grant;
    logic [BCW-1:0] byte_cnt;
    logic [WDW-1:0] wdog;
    logic           last_flag;
    logic           grant_active_q;
    logic           tx_timeout_q;

    logic [7:0]       lane [N_REQ];
    logic [IDW-1:0]   sel_idx;
    logic             sel_found;
    logic [N_REQ-1:0] ready_vec;
    logic             tx_start_c;
    logic [7:0]       tx_data_c;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign lane[g] = bus.req_data[8*g +: 8];
    end

    // First valid requester after the previous owner, wrapping around.
    always_comb begin : sel_blk
        int idx;
        idx       = 0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!sel_found && bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        ready_vec  = '0;
        tx_start_c = 1'b0;
        tx_data_c  = '0;
        if (state == S_LOAD) begin
            ready_vec[grant_q] = 1'b1;
            tx_start_c         = bus.req_valid[grant_q];
            tx_data_c          = lane[grant_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            grant_q        <= '0;
            last_grant     <= IDW'(N_REQ - 1);
            byte_cnt       <= '0;
            wdog           <= '0;
            last_flag      <= 1'b0;
            grant_active_q <= 1'b0;
            tx_timeout_q   <= 1'b0;
        end else begin
            tx_timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        grant_q        <= sel_idx;
                        grant_active_q <= 1'b1;
                        byte_cnt       <= '0;
                        state          <= S_LOAD;
                    end
                end
                // The owner may pause between bytes indefinitely; it frames the packet.
                S_LOAD: begin
                    if (bus.req_valid[grant_q]) begin
                        last_flag <= bus.req_last[grant_q];
                        byte_cnt  <= byte_cnt + BCW'(1);
                        wdog      <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        if (last_flag || byte_cnt == BCW'(MAX_BURST)) begin
                            last_grant     <= grant_q;
                            grant_active_q <= 1'b0;
                            state          <= S_IDLE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        tx_timeout_q   <= 1'b1;
                        last_grant     <= grant_q;
                        grant_active_q <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.tx_start     = tx_start_c;
    assign bus.tx_data      = tx_data_c;
    assign bus.grant_active = grant_active_q;
    assign bus.grant_id     = grant_q;
    assign bus.tx_timeout   = tx_timeout_q;
    assign bus.fsm_state    = state;
endmodule
